// File: rtl/sync_fifo_pkg.sv
// Shared width helpers for the sync FIFO family.
package sync_fifo_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// FIFO pointer: index 0..DEPTH-1 plus a wrap bit that toggles on each lap.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      inc,
  output logic [addr_w(DEPTH)-1:0]  idx,
  output logic                      wrap
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Explicit compare against DEPTH-1 so non-power-of-2 depths wrap correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      wrap <= 1'b0;
    end else if (flush) begin
      idx  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (idx == LAST_IDX) begin
        idx  <= '0;
        wrap <= ~wrap;
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO, any DEPTH >= 2, with occupancy count, threshold flags,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter type         T        = logic,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wen,
  input  T                         data_in,
  input  logic                     ren,
  output T                         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  typedef struct packed {
    logic          wrap;
    logic [AW-1:0] idx;
  } fifo_ptr_t;

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_v2: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_v2: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_v2: AE_LEVEL must be in 0..DEPTH-1");
  end

  T              r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;
  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;
  logic          w_wwrap;
  logic          w_rwrap;
  fifo_ptr_t     w_wptr;
  fifo_ptr_t     w_rptr;
  logic          w_wr_acc;
  logic          w_rd_acc;

  assign w_wptr = '{wrap: w_wwrap, idx: w_widx};
  assign w_rptr = '{wrap: w_rwrap, idx: w_ridx};

  // Flush suppresses both accepts so the cycle's requests vanish silently.
  assign w_wr_acc = ~flush & wen & (~full | ren);
  assign w_rd_acc = ~flush & ren & ~empty;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (w_wr_acc),
    .idx   (w_widx),
    .wrap  (w_wwrap)
  );

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (w_rd_acc),
    .idx   (w_ridx),
    .wrap  (w_rwrap)
  );

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_widx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - 1'b1;
      if (wen && !w_wr_acc) r_overflow  <= 1'b1;
      if (ren && !w_rd_acc) r_underflow <= 1'b1;
    end
  end

  assign data_out     = r_mem[w_ridx];
  assign count        = r_count;
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  a_full_ptr: assert property (@(posedge clk) disable iff (!rst_n)
    full == ((w_wptr.idx == w_rptr.idx) && (w_wptr.wrap != w_rptr.wrap)));
  a_empty_ptr: assert property (@(posedge clk) disable iff (!rst_n)
    empty == (w_wptr == w_rptr));

endmodule
